// File: rtl/sync_event_pkg.sv
// Shared types for the synchronized-level event capture block: edge kind,
// queued event record and a small constructor helper.
package sync_event_pkg;

  // Storage width of an event timestamp; the top's TS_WIDTH must not exceed it.
  localparam int unsigned EV_TS_WIDTH = 16;

  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_e;

  // 'edge' is a reserved word, hence edge_type.
  typedef struct packed {
    edge_e                  edge_type;
    logic [EV_TS_WIDTH-1:0] ts;
  } event_t;

  function automatic event_t make_event(input logic is_rise,
                                        input logic [EV_TS_WIDTH-1:0] ts);
    event_t ev;
    ev.edge_type = is_rise ? EDGE_RISE : EDGE_FALL;
    ev.ts        = ts;
    return ev;
  endfunction

endpackage

// File: rtl/sync_event_fifo.sv
// First-word-fall-through FIFO of event records. A push into a full FIFO
// with no simultaneous pop is discarded and reported on the drop strobe.
module sync_event_fifo
  import sync_event_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk_2,
  input  logic   rst,
  input  logic   push,
  input  event_t push_data,
  input  logic   pop_ready,
  output logic   valid,
  output event_t head,
  output logic   drop
);

  localparam int unsigned    AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

  event_t          mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            full_s;
  logic            pop_s;
  logic            wr_en_s;
  logic            drop_s;

  // Accept/drop decision; a pop in the same cycle frees the slot for the push.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    pop_s   = (count_r != '0) & pop_ready;
    wr_en_s = push & (~full_s | pop_s);
    drop_s  = push & full_s & ~pop_s;
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk_2) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk_2) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
        2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = (count_r != '0);
  assign head  = mem_r[rd_ptr_r];
  assign drop  = drop_s;

endmodule

// File: rtl/sync_event_capture.sv
// Deglitches a synchronized level, emits registered edge pulses, timestamps
// each accepted edge and queues it for a valid/ready consumer.
module sync_event_capture
  import sync_event_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned TS_WIDTH   = EV_TS_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_2,
  input  logic                rst,
  input  logic                i_sync,
  input  logic                i_clear_ovf,
  input  logic                i_ev_ready,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_ev_valid,
  output logic                o_ev_edge,
  output logic [TS_WIDTH-1:0] o_ev_ts,
  output logic                o_overflow
);

  // Count value at which the next differing sample completes the run.
  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic                level_r;
  logic                rise_r;
  logic                fall_r;
  logic                ovf_r;
  logic [3:0]          cnt_r;
  logic [TS_WIDTH-1:0] ts_r;

  logic                diff_s;
  logic                accept_s;
  logic                push_s;
  event_t              ev_in_s;
  event_t              head_s;
  logic                valid_s;
  logic                drop_s;

  // Filter decision and the event record built while a pulse is visible.
  always_comb begin
    diff_s   = i_sync ^ level_r;
    accept_s = diff_s & (cnt_r == CNT_LAST);
    push_s   = rise_r | fall_r;
    ev_in_s  = make_event(rise_r, EV_TS_WIDTH'(ts_r));
  end

  // Level filter and edge pulses; the pulse appears with the new level.
  always_ff @(posedge clk_2) begin
    if (rst) begin
      level_r <= 1'b0;
      cnt_r   <= 4'd0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= accept_s & ~level_r;
      fall_r <= accept_s & level_r;
      if (accept_s) begin
        level_r <= ~level_r;
        cnt_r   <= 4'd0;
      end else if (diff_s) begin
        cnt_r   <= cnt_r + 4'd1;
      end else begin
        cnt_r   <= 4'd0;
      end
    end
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk_2) begin
    if (rst) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1'b1);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_2) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (i_clear_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  sync_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_2     (clk_2),
    .rst       (rst),
    .push      (push_s),
    .push_data (ev_in_s),
    .pop_ready (i_ev_ready),
    .valid     (valid_s),
    .head      (head_s),
    .drop      (drop_s)
  );

  assign o_level    = level_r;
  assign o_rise     = rise_r;
  assign o_fall     = fall_r;
  assign o_overflow = ovf_r;
  assign o_ev_valid = valid_s;
  assign o_ev_edge  = head_s.edge_type;
  assign o_ev_ts    = head_s.ts[TS_WIDTH-1:0];

endmodule

// File: tb/tb_sync_event_capture.sv
// Scoreboard bench: a behavioural model predicts level/pulses/overflow and the
// event stream; a negedge monitor compares two DUT instances (16- and 4-bit ts).
module tb_sync_event_capture;
  import sync_event_pkg::*;

  localparam int FL    = 3;
  localparam int DEPTH = 4;

  logic        clk_2 = 1'b0;
  logic        rst = 1'b1;
  logic        i_sync = 1'b0;
  logic        i_clear_ovf = 1'b0;
  logic        i_ev_ready = 1'b0;

  logic        lvl_a, rise_a, fall_a, valid_a, edge_a, ovf_a;
  logic [15:0] ts_a;
  logic        lvl_b, rise_b, fall_b, valid_b, edge_b, ovf_b;
  logic [3:0]  ts_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          e;
    int unsigned ts;
  } exp_ev_t;

  exp_ev_t     exp_q[$];
  bit          m_level, m_rise, m_fall, m_ovf, checking;
  int unsigned m_cyc, m_run;
  logic [15:0] cap_a_ts[$];
  logic        cap_a_edge[$];
  logic [3:0]  cap_b_ts[$];

  always #5 clk_2 = ~clk_2;

  sync_event_capture #(.FILTER_LEN(FL), .TS_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk_2(clk_2), .rst(rst), .i_sync(i_sync), .i_clear_ovf(i_clear_ovf),
    .i_ev_ready(i_ev_ready), .o_level(lvl_a), .o_rise(rise_a), .o_fall(fall_a),
    .o_ev_valid(valid_a), .o_ev_edge(edge_a), .o_ev_ts(ts_a), .o_overflow(ovf_a));

  sync_event_capture #(.FILTER_LEN(FL), .TS_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk_2(clk_2), .rst(rst), .i_sync(i_sync), .i_clear_ovf(i_clear_ovf),
    .i_ev_ready(i_ev_ready), .o_level(lvl_b), .o_rise(rise_b), .o_fall(fall_b),
    .o_ev_valid(valid_b), .o_ev_edge(edge_b), .o_ev_ts(ts_b), .o_overflow(ovf_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: run of samples differing from the level, cycles since
  // reset as timestamp, and an occupancy-limited expected event list.
  task automatic model_step();
    bit drop;
    if (rst) begin
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_ovf = 1'b0;
      m_cyc = 0; m_run = 0; exp_q.delete(); checking = 1'b1;
    end else begin
      drop = 1'b0;
      if (m_rise || m_fall) begin
        if (exp_q.size() < DEPTH) exp_q.push_back('{e: m_rise, ts: m_cyc});
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (i_clear_ovf) m_ovf = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (i_sync == m_level) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == FL) begin
          m_rise  = !m_level;
          m_fall  = m_level;
          m_level = !m_level;
          m_run   = 0;
        end
      end
      m_cyc++;
    end
  endtask

  task automatic monitor_step();
    bit have;
    have = (exp_q.size() > 0);
    chk("level_a", 32'(lvl_a), 32'(m_level));
    chk("level_b", 32'(lvl_b), 32'(m_level));
    chk("rise_a", 32'(rise_a), 32'(m_rise));
    chk("fall_a", 32'(fall_a), 32'(m_fall));
    chk("rise_b", 32'(rise_b), 32'(m_rise));
    chk("fall_b", 32'(fall_b), 32'(m_fall));
    chk("ovf_a", 32'(ovf_a), 32'(m_ovf));
    chk("ovf_b", 32'(ovf_b), 32'(m_ovf));
    chk("valid_a", 32'(valid_a), 32'(have));
    chk("valid_b", 32'(valid_b), 32'(have));
    if (have) begin
      chk("head_edge_a", 32'(edge_a), 32'(exp_q[0].e));
      chk("head_ts_a", 32'(ts_a), exp_q[0].ts & 32'h0000_FFFF);
      chk("head_edge_b", 32'(edge_b), 32'(exp_q[0].e));
      chk("head_ts_b", 32'(ts_b), exp_q[0].ts & 32'h0000_000F);
      if (i_ev_ready) begin
        cap_a_ts.push_back(ts_a);
        cap_a_edge.push_back(edge_a);
        cap_b_ts.push_back(ts_b);
        void'(exp_q.pop_front());
      end
    end
  endtask

  initial forever begin
    @(posedge clk_2);
    model_step();
  end

  initial forever begin
    @(negedge clk_2);
    if (checking) monitor_step();
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_2);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; i_sync = 1'b0; i_clear_ovf = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic clear_caps();
    cap_a_ts.delete(); cap_a_edge.delete(); cap_b_ts.delete();
  endtask

  task automatic wait_pulse(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      seen = m_rise || m_fall;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int unsigned exp_new;
    int          run_left;
    int          ready_pct;

    // Reset held with input high; level follows three samples after release.
    rst = 1'b1; i_sync = 1'b1;
    step(3);
    chk("rst_level", 32'(lvl_a), 32'd0);
    chk("rst_rise", 32'(rise_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    rst = 1'b0;
    step(2);
    chk("pre_accept_level", 32'(lvl_a), 32'd0);
    step(1);
    chk("accept_level", 32'(lvl_a), 32'd1);
    chk("accept_rise", 32'(rise_a), 32'd1);
    step(2);
    chk("first_event_valid", 32'(valid_a), 32'd1);

    // Two-sample glitch is rejected.
    i_ev_ready = 1'b1;
    do_reset();
    i_sync = 1'b1; step(2);
    i_sync = 1'b0; step(5);
    chk("glitch_level", 32'(lvl_a), 32'd0);
    chk("glitch_valid", 32'(valid_a), 32'd0);

    // Rise stamped 0x0010, fall 20 cycles later at 0x0024.
    clear_caps();
    do_reset();
    step(13);
    i_sync = 1'b1; step(20);
    i_sync = 1'b0; step(6);
    chk("ts_event_count", 32'(cap_a_ts.size()), 32'd2);
    if (cap_a_ts.size() >= 2) begin
      chk("ts_rise_edge", 32'(cap_a_edge[0]), 32'd1);
      chk("ts_rise_value", 32'(cap_a_ts[0]), 32'h0010);
      chk("ts_fall_edge", 32'(cap_a_edge[1]), 32'd0);
      chk("ts_fall_value", 32'(cap_a_ts[1]), 32'h0024);
    end

    // 4-bit timestamp wraps: 0xF then 0x2.
    clear_caps();
    do_reset();
    step(12);
    i_sync = 1'b1; step(3);
    i_sync = 1'b0; step(6);
    chk("wrap_event_count", 32'(cap_b_ts.size()), 32'd2);
    if (cap_b_ts.size() >= 2) begin
      chk("wrap_ts0", 32'(cap_b_ts[0]), 32'hF);
      chk("wrap_ts1", 32'(cap_b_ts[1]), 32'h2);
    end

    // Five edges into a depth-4 FIFO with no consumer.
    do_reset();
    i_ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_sync = (k % 2 == 0) ? 1'b1 : 1'b0;
      step(4);
    end
    step(1);
    chk("overflow_set", 32'(ovf_a), 32'd1);
    clear_caps();
    i_ev_ready = 1'b1; step(6); i_ev_ready = 1'b0;
    chk("drain_count", 32'(cap_a_ts.size()), 32'd4);
    for (int k = 0; k < 4 && k < cap_a_edge.size(); k++)
      chk("drain_order", 32'(cap_a_edge[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
    i_clear_ovf = 1'b1; step(1); i_clear_ovf = 1'b0;
    chk("overflow_cleared", 32'(ovf_a), 32'd0);

    // Refill, then clear in the same cycle as a drop: set wins.
    for (int k = 0; k < 4; k++) begin
      i_sync = (k % 2 == 0) ? 1'b0 : 1'b1;
      step(4);
    end
    i_sync = 1'b0;
    wait_pulse("drop_pulse_wait");
    i_clear_ovf = 1'b1; step(1); i_clear_ovf = 1'b0;
    chk("clear_vs_drop", 32'(ovf_a), 32'd1);
    i_clear_ovf = 1'b1; step(1); i_clear_ovf = 1'b0;
    chk("overflow_cleared2", 32'(ovf_a), 32'd0);

    // Full FIFO: pop and push in the same cycle, nothing dropped.
    i_sync = 1'b1;
    wait_pulse("pushpop_pulse_wait");
    exp_new = m_cyc;
    clear_caps();
    i_ev_ready = 1'b1; step(1); i_ev_ready = 1'b0;
    step(1);
    chk("pushpop_no_drop", 32'(ovf_a), 32'd0);
    chk("pushpop_valid", 32'(valid_a), 32'd1);
    i_ev_ready = 1'b1; step(6); i_ev_ready = 1'b0;
    chk("pushpop_total", 32'(cap_a_ts.size()), 32'd5);
    if (cap_a_ts.size() >= 5) begin
      chk("pushpop_last_edge", 32'(cap_a_edge[4]), 32'd1);
      chk("pushpop_last_ts", 32'(cap_a_ts[4]), exp_new & 32'h0000_FFFF);
    end

    // Randomized traffic with varying consumer pressure and occasional resets.
    do_reset();
    run_left  = 0;
    ready_pct = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) ready_pct = $urandom_range(0, 10);
      if (run_left == 0) begin
        i_sync   = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 6);
      end
      run_left--;
      i_ev_ready  = ($urandom_range(0, 9) < ready_pct) ? 1'b1 : 1'b0;
      i_clear_ovf = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      rst         = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
      step(1);
    end
    rst = 1'b0; i_clear_ovf = 1'b0; i_ev_ready = 1'b1;
    step(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
